mempool_l2_mem_ctrl: RTL and testbench

// - Request/response stage between the L2 axi2mem memory port and the L2 tc_sram macro.
// - Accepts word requests (req/gnt), translates byte addresses to word indices and range-checks them.
// - Drives the SRAM, tracks its fixed read latency in a valid pipe and returns exactly one rvalid per grant.
// - Caps in-flight requests with a credit counter so the upstream response buffer can never overflow.

---
 rtl/mempool_l2_mem_ctrl_if.sv | 14 +
 rtl/mempool_l2_mem_ctrl.sv | 84 ++++++++
 tb/tb_mempool_l2_mem_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mempool_l2_mem_ctrl_if.sv
// mempool_l2_mem_ctrl_if: upstream word request/response bus of the L2 memory controller
// master drives requests, slave answers with grant and one rvalid per grant.
interface mempool_l2_mem_ctrl_if #(
  parameter int DataWidth = 512,
  parameter int AddrWidth = 32
);
  localparam int BeWidth = DataWidth / 8;
  logic req, gnt, we, rvalid;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wdata, rdata;
  logic [BeWidth-1:0] strb;
  modport master (output req, addr, we, wdata, strb, input gnt, rvalid, rdata);
  modport slave (input req, addr, we, wdata, strb, output gnt, rvalid, rdata);
endinterface

// File: rtl/mempool_l2_mem_ctrl.sv
// mempool_l2_mem_ctrl: L2 req/gnt to tc_sram stage with latency-tracking valid pipe and credit cap
// Defining L2_MEM_CTRL_STATS_EN adds saturating read/write/stall counters.
module mempool_l2_mem_ctrl #(
  parameter int DataWidth = 512,
  parameter int AddrWidth = 32,
  parameter int NumWords = 1024,
  parameter int ByteOffset = 6,
  parameter int SramLatency = 1,
  parameter int MaxOutstanding = 2,
  localparam int BeWidth = DataWidth / 8,
  localparam int WordAddrWidth = $clog2(NumWords)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  mempool_l2_mem_ctrl_if.slave     mem,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [WordAddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0]     sram_wdata_o,
  output logic [BeWidth-1:0]       sram_be_o,
  input  logic [DataWidth-1:0]     sram_rdata_i,
`ifdef L2_MEM_CTRL_STATS_EN
  output logic [31:0]              stat_reads_o,
  output logic [31:0]              stat_writes_o,
  output logic [31:0]              stat_stall_o,
`endif
  output logic                     oor_err_o,
  output logic                     busy_o
);
  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam int HiLsb = ByteOffset + WordAddrWidth;
  logic [CntWidth-1:0] r_cnt, w_cnt_dec;
  logic [SramLatency-1:0] r_vld, r_rd, r_oor;
  logic [WordAddrWidth-1:0] w_idx;
  logic w_oor, w_gnt, w_rvalid, r_oor_err, w_unused_lsb;
  assign w_idx = mem.addr[ByteOffset +: WordAddrWidth];
  assign w_oor = (|(mem.addr >> HiLsb)) || (int'(w_idx) >= NumWords);
  assign w_rvalid = r_vld[SramLatency-1];
  // a credit returned by this cycle's rvalid may be spent by this cycle's grant
  assign w_cnt_dec = r_cnt - CntWidth'(w_rvalid);
  assign w_gnt = mem.req && (w_cnt_dec < CntWidth'(MaxOutstanding));
  assign mem.gnt = w_gnt;
  assign mem.rvalid = w_rvalid;
  assign mem.rdata = (w_rvalid && r_rd[SramLatency-1] && !r_oor[SramLatency-1]) ? sram_rdata_i : '0;
  assign sram_req_o = w_gnt && !w_oor;
  assign sram_we_o = mem.we;
  assign sram_addr_o = w_idx;
  assign sram_wdata_o = mem.wdata;
  assign sram_be_o = mem.strb;
  assign oor_err_o = r_oor_err;
  assign busy_o = r_cnt != '0;
  assign w_unused_lsb = ^mem.addr[ByteOffset-1:0];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_cnt <= '0;
      r_vld <= '0;
      r_rd <= '0;
      r_oor <= '0;
      r_oor_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_dec + CntWidth'(w_gnt);
      r_vld <= (r_vld << 1) | SramLatency'(w_gnt);
      r_rd <= (r_rd << 1) | SramLatency'(!mem.we);
      r_oor <= (r_oor << 1) | SramLatency'(w_oor);
      r_oor_err <= w_gnt && w_oor;
    end
  a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i) r_cnt <= CntWidth'(MaxOutstanding));
`ifdef L2_MEM_CTRL_STATS_EN
  logic [31:0] r_reads, r_writes, r_stall;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_reads <= '0;
      r_writes <= '0;
      r_stall <= '0;
    end else begin
      r_reads <= r_reads + 32'(w_gnt && !mem.we && r_reads != '1);
      r_writes <= r_writes + 32'(w_gnt && mem.we && r_writes != '1);
      r_stall <= r_stall + 32'(mem.req && !w_gnt && r_stall != '1);
    end
  assign stat_reads_o = r_reads;
  assign stat_writes_o = r_writes;
  assign stat_stall_o = r_stall;
`endif
endmodule

// File: tb/tb_mempool_l2_mem_ctrl.sv
// tb_mempool_l2_mem_ctrl: scoreboard bench for mempool_l2_mem_ctrl at SramLatency 1 and 4
module tb_mempool_l2_mem_ctrl;
  localparam int DW = 512, AW = 32, BW = 64, NW = 1024, WAW = 10;
  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0, total = 0, bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mempool_l2_mem_ctrl_if #(.DataWidth(DW), .AddrWidth(AW)) m1 ();
  mempool_l2_mem_ctrl_if #(.DataWidth(DW), .AddrWidth(AW)) m4 ();
  logic s1_req, s1_we, oor1, busy1, s4_req, s4_we, oor4, busy4;
  logic [WAW-1:0] s1_addr, s4_addr;
  logic [DW-1:0] s1_wdata, s4_wdata, s1_rdata, s4_rdata;
  logic [BW-1:0] s1_be, s4_be;
`ifdef L2_MEM_CTRL_STATS_EN
  logic [31:0] sr1, sw1, ss1, sr4, sw4, ss4;
`endif

  mempool_l2_mem_ctrl #(.SramLatency(1), .MaxOutstanding(2)) u_d1 (
    .clk_i(clk), .rst_i(rst), .mem(m1),
    .sram_req_o(s1_req), .sram_we_o(s1_we), .sram_addr_o(s1_addr), .sram_wdata_o(s1_wdata),
    .sram_be_o(s1_be), .sram_rdata_i(s1_rdata),
`ifdef L2_MEM_CTRL_STATS_EN
    .stat_reads_o(sr1), .stat_writes_o(sw1), .stat_stall_o(ss1),
`endif
    .oor_err_o(oor1), .busy_o(busy1));

  mempool_l2_mem_ctrl #(.SramLatency(4), .MaxOutstanding(2)) u_d4 (
    .clk_i(clk), .rst_i(rst), .mem(m4),
    .sram_req_o(s4_req), .sram_we_o(s4_we), .sram_addr_o(s4_addr), .sram_wdata_o(s4_wdata),
    .sram_be_o(s4_be), .sram_rdata_i(s4_rdata),
`ifdef L2_MEM_CTRL_STATS_EN
    .stat_reads_o(sr4), .stat_writes_o(sw4), .stat_stall_o(ss4),
`endif
    .oor_err_o(oor4), .busy_o(busy4));

  // SRAM models: latency 1 (registered read) and latency 4 (three extra stages)
  logic [DW-1:0] mem1 [NW];
  logic [DW-1:0] mem4 [NW];
  logic [DW-1:0] p4 [4];
  always @(posedge clk) begin
    if (s1_req) begin
      for (int b = 0; b < BW; b++) if (s1_we && s1_be[b]) mem1[s1_addr][8*b +: 8] <= s1_wdata[8*b +: 8];
      s1_rdata <= mem1[s1_addr];
    end
  end
  always @(posedge clk) begin
    if (s4_req) for (int b = 0; b < BW; b++) if (s4_we && s4_be[b]) mem4[s4_addr][8*b +: 8] <= s4_wdata[8*b +: 8];
    p4[0] <= mem4[s4_addr];
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign s4_rdata = p4[3];

  exp_t q1[$], q4[$];
  always @(negedge clk) if (m1.rvalid) begin
    exp_t e;
    total++;
    if (q1.size() == 0) begin
      bad++;
      $display("FAIL d1_unexpected_rvalid cyc=%0d rdata=%h", cyc, m1.rdata);
    end else begin
      e = q1.pop_front();
      if (m1.rdata !== e.data || cyc != e.due) begin
        bad++;
        $display("FAIL d1_resp cyc=%0d due=%0d got=%h exp=%h", cyc, e.due, m1.rdata, e.data);
      end
    end
  end
  always @(negedge clk) if (m4.rvalid) begin
    exp_t e;
    total++;
    if (q4.size() == 0) begin
      bad++;
      $display("FAIL d4_unexpected_rvalid cyc=%0d rdata=%h", cyc, m4.rdata);
    end else begin
      e = q4.pop_front();
      if (m4.rdata !== e.data || cyc != e.due) begin
        bad++;
        $display("FAIL d4_resp cyc=%0d due=%0d got=%h exp=%h", cyc, e.due, m4.rdata, e.data);
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic op1(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [BW-1:0] strb, input logic oor, input logic [DW-1:0] exp);
    int n = 0;
    exp_t e;
    @(posedge clk); #1;
    m1.req = 1'b1; m1.we = we; m1.addr = addr; m1.wdata = wdata; m1.strb = strb;
    @(negedge clk);
    while (!m1.gnt && n < 20) begin n++; @(negedge clk); end
    check("d1_gnt", m1.gnt, 1);
    if (m1.gnt) begin
      e.data = exp; e.due = cyc + 1;
      q1.push_back(e);
      check("d1_sram_req", s1_req, !oor);
      if (!oor) check("d1_sram_addr", s1_addr, addr[15:6]);
    end
  endtask

  task automatic idle1();
    @(posedge clk); #1;
    m1.req = 1'b0;
  endtask

  task automatic idle4();
    @(posedge clk); #1;
    m4.req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [DW-1:0] ed;
    int k, n;
    m1.req = 0; m1.we = 0; m1.addr = '0; m1.wdata = '0; m1.strb = '0;
    m4.req = 0; m4.we = 0; m4.addr = '0; m4.wdata = '0; m4.strb = '0;
    repeat (2) @(negedge clk);
    check("rst_rvalid", m1.rvalid, 0);
    check("rst_rdata", m1.rdata, '0);
    check("rst_oor", oor1, 0);
    check("rst_busy", busy1, 0);
    check("rst_gnt_idle", m1.gnt, 0);
    check("rst_busy4", busy4, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // read after write at latency 1
    op1(1, 32'h80, {64{8'hA5}}, '1, 0, '0);
    op1(0, 32'h80, '0, '0, 0, {64{8'hA5}});
    check("d1_busy", busy1, 1);
    idle1();
    // partial strobe on word 3
    op1(1, 32'hC0, {64{8'hFF}}, '1, 0, '0);
    op1(1, 32'hC0, 512'h11, 64'h1, 0, '0);
    op1(0, 32'hC0, '0, '0, 0, {{63{8'hFF}}, 8'h11});
    idle1();
    // last in-range word
    op1(1, 32'hFFC0, {64{8'h3C}}, '1, 0, '0);
    op1(0, 32'hFFC0, '0, '0, 0, {64{8'h3C}});
    idle1();
    // out-of-range read, error pulse one cycle later
    op1(0, 32'h8001_0000, '0, '0, 1, '0);
    idle1();
    @(negedge clk);
    check("d1_oor_pulse", oor1, 1);
    @(negedge clk);
    check("d1_oor_clear", oor1, 0);
    // out-of-range write must not alias onto word 2
    op1(1, 32'h8001_0080, {64{8'h5A}}, '1, 1, '0);
    op1(0, 32'h0001_0000, '0, '0, 1, '0);
    op1(0, 32'h80, '0, '0, 0, {64{8'hA5}});
    idle1();
    for (int i = 0; i < 50 && q1.size() != 0; i++) @(negedge clk);
    check("d1_drain", q1.size(), 0);

    // credit limit at latency 4: gnt 1,1,0,0 repeating while req held
    k = 0; n = 0;
    while (n < 8 && k < 40) begin
      @(posedge clk); #1;
      m4.req = 1'b1; m4.we = n < 4; m4.addr = AW'((n % 4) * 64);
      m4.wdata = {64{8'(n % 4 + 1)}}; m4.strb = '1;
      @(negedge clk);
      check("d4_gnt_pattern", m4.gnt, (k % 4) < 2);
      if (k > 0) check("d4_busy", busy4, 1);
      if (m4.gnt) begin
        ed = (n < 4) ? '0 : {64{8'(n % 4 + 1)}};
        e.data = ed; e.due = cyc + 4;
        q4.push_back(e);
        n++;
      end
      k++;
    end
    idle4();
    for (int i = 0; i < 50 && q4.size() != 0; i++) @(negedge clk);
    check("d4_drain", q4.size(), 0);
`ifdef L2_MEM_CTRL_STATS_EN
    check("d4_stat_reads", sr4, 4);
    check("d4_stat_writes", sw4, 4);
    check("d4_stat_stall", ss4, 6);
`endif

    // reset with two reads in flight
    @(posedge clk); #1;
    m4.req = 1'b1; m4.we = 1'b0; m4.addr = 32'h40;
    @(negedge clk);
    check("d4_pre_rst_gnt0", m4.gnt, 1);
    @(posedge clk); #1;
    m4.addr = 32'h80;
    @(negedge clk);
    check("d4_pre_rst_gnt1", m4.gnt, 1);
    @(posedge clk); #1;
    m4.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("d4_rst_busy", busy4, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("d4_no_rvalid", m4.rvalid, 0);
    end
    @(posedge clk); #1;
    m4.req = 1'b1; m4.addr = 32'hC0;
    @(negedge clk);
    check("d4_post_rst_gnt", m4.gnt, 1);
    if (m4.gnt) begin
      e.data = {64{8'h04}}; e.due = cyc + 4;
      q4.push_back(e);
    end
    idle4();
    for (int i = 0; i < 50 && q4.size() != 0; i++) @(negedge clk);
    check("d4_post_rst_drain", q4.size(), 0);
`ifdef L2_MEM_CTRL_STATS_EN
    check("d4_stat_reads_post_rst", sr4, 1);
    check("d4_stat_stall_post_rst", ss4, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
